// File: rtl/pic_pkg.sv
// pic_pkg: shared constants for the PIC interrupt request / in-service stage.
//   NUM_IRQ       - number of request lines (fixed at 8)
//   LOW_PRIO_RST  - lowest-priority level after reset (IR0 then has top priority)
//   IDLE/WAIT_ACK2 - resolver FSM state encoding
//   EOI_* / ROT_* / SET_PRIO - OCW2 {R,SL,EOI} command encodings
//   SPURIOUS_ID   - id returned when ack1 finds no candidate
package pic_pkg;

    localparam int unsigned NUM_IRQ      = 8;
    localparam logic [2:0]  LOW_PRIO_RST = 3'd7;

    // Resolver FSM states
    localparam logic [0:0] IDLE      = 1'b0;
    localparam logic [0:0] WAIT_ACK2 = 1'b1;

    // OCW2 {R,SL,EOI} commands
    localparam logic [2:0] EOI_NS   = 3'b001;
    localparam logic [2:0] EOI_SP   = 3'b011;
    localparam logic [2:0] ROT_NS   = 3'b101;
    localparam logic [2:0] ROT_SP   = 3'b111;
    localparam logic [2:0] SET_PRIO = 3'b110;

    localparam logic [2:0] SPURIOUS_ID = 3'd7;

    // Priority rank of level idx given lowest level low: 0 is highest priority.
    function automatic logic [2:0] prio_rank(input logic [2:0] idx, input logic [2:0] low);
        return idx - low - 3'd1;
    endfunction

endpackage

// File: rtl/pic_irq_resolver_if.sv
// pic_irq_resolver_if: request, mask, acknowledge and OCW2 signals between the
// PIC control logic (master) and the request/in-service resolver (slave).
//   ir_in, ltim, imr, aeoi           - request lines and configuration
//   ack1, ack2                       - INTA pulse strobes
//   eoi_valid, eoi_cmd, eoi_level    - OCW2 write
//   int_req, int_id, irr, isr, lowest_prio - resolver status back to control
interface pic_irq_resolver_if;

    logic [7:0] ir_in;
    logic       ltim;
    logic [7:0] imr;
    logic       aeoi;
    logic       ack1;
    logic       ack2;
    logic       eoi_valid;
    logic [2:0] eoi_cmd;
    logic [2:0] eoi_level;
    logic       int_req;
    logic [2:0] int_id;
    logic [7:0] irr;
    logic [7:0] isr;
    logic [2:0] lowest_prio;

    modport master (
        output ir_in, ltim, imr, aeoi, ack1, ack2, eoi_valid, eoi_cmd, eoi_level,
        input  int_req, int_id, irr, isr, lowest_prio
    );

    modport slave (
        input  ir_in, ltim, imr, aeoi, ack1, ack2, eoi_valid, eoi_cmd, eoi_level,
        output int_req, int_id, irr, isr, lowest_prio
    );

endinterface

// File: rtl/pic_rot_prio_enc.sv
// pic_rot_prio_enc: combinational rotating priority encoder.
//   vec   in  8  request vector
//   low   in  3  lowest-priority level; (low+1) mod 8 is highest
//   valid out 1  any bit of vec set
//   idx   out 3  highest-priority set bit
module pic_rot_prio_enc
    import pic_pkg::*;
(
    input  logic [7:0] vec,
    input  logic [2:0] low,
    output logic       valid,
    output logic [2:0] idx
);

    logic [2:0] pos;

    // Scan from lowest priority (k=8 -> low) up to highest (k=1), so the
    // last hit is the winner.
    always_comb begin
        valid = 1'b0;
        idx   = 3'd0;
        pos   = 3'd0;
        for (int k = NUM_IRQ; k >= 1; k--) begin
            pos = low + 3'(k);
            if (vec[pos]) begin
                valid = 1'b1;
                idx   = pos;
            end
        end
    end

endmodule

// File: rtl/pic_irq_resolver.sv
// pic_irq_resolver: PIC interrupt request register, masking, priority
// resolution (fully nested / rotating), in-service tracking and EOI handling.
//   clk    in  system clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   bus    slave modport of pic_irq_resolver_if (requests, acks, OCW2, status)
module pic_irq_resolver
    import pic_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    pic_irq_resolver_if.slave  bus
);

    logic [7:0] ir_q;
    logic [7:0] irr_q, irr_d;
    logic [7:0] isr_q, isr_d;
    logic [0:0] state_q, state_d;
    logic       int_req_q, int_req_d;
    logic [2:0] int_id_q, int_id_d;
    logic       spur_q, spur_d;
    logic [2:0] low_q, low_d;

    logic       cand_vld, top_vld;
    logic [2:0] cand_idx, top_idx;
    logic [7:0] edge_det, grant_mask, clr_mask;
    logic       ack1_take, ack2_take, grant;

    pic_rot_prio_enc u_cand_enc (
        .vec   (irr_q & ~bus.imr),
        .low   (low_q),
        .valid (cand_vld),
        .idx   (cand_idx)
    );

    pic_rot_prio_enc u_isr_enc (
        .vec   (isr_q),
        .low   (low_q),
        .valid (top_vld),
        .idx   (top_idx)
    );

    always_comb begin
        edge_det   = bus.ir_in & ~ir_q;
        ack1_take  = bus.ack1 && (state_q == IDLE);
        ack2_take  = bus.ack2 && (state_q == WAIT_ACK2);
        grant      = ack1_take && cand_vld;
        grant_mask = grant ? (8'd1 << cand_idx) : 8'd0;

        state_d  = state_q;
        int_id_d = int_id_q;
        spur_d   = spur_q;
        low_d    = low_q;
        clr_mask = 8'd0;

        if (bus.eoi_valid) begin
            case (bus.eoi_cmd)
                EOI_NS: if (top_vld) clr_mask = 8'd1 << top_idx;
                EOI_SP: clr_mask = 8'd1 << bus.eoi_level;
                ROT_NS: begin
                    if (top_vld) begin
                        clr_mask = 8'd1 << top_idx;
                        low_d    = top_idx;
                    end
                end
                ROT_SP: begin
                    clr_mask = 8'd1 << bus.eoi_level;
                    low_d    = bus.eoi_level;
                end
                SET_PRIO: low_d = bus.eoi_level;
                default: ;
            endcase
        end

        if (ack1_take) begin
            state_d  = WAIT_ACK2;
            int_id_d = cand_vld ? cand_idx : SPURIOUS_ID;
            spur_d   = !cand_vld;
        end else if (ack2_take) begin
            state_d = IDLE;
            if (bus.aeoi && !spur_q) clr_mask = clr_mask | (8'd1 << int_id_q);
        end

        // Clear before set: a same-cycle ack1 set or fresh edge always wins.
        isr_d = (isr_q & ~clr_mask) | grant_mask;
        irr_d = ((bus.ltim ? bus.ir_in : irr_q) & ~grant_mask) | edge_det;

        int_req_d = (state_q == IDLE) && !bus.ack1 && cand_vld &&
                    (!top_vld || (prio_rank(cand_idx, low_q) < prio_rank(top_idx, low_q)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_q      <= 8'hFF;
            irr_q     <= 8'd0;
            isr_q     <= 8'd0;
            state_q   <= IDLE;
            int_req_q <= 1'b0;
            int_id_q  <= 3'd0;
            spur_q    <= 1'b0;
            low_q     <= LOW_PRIO_RST;
        end else begin
            ir_q      <= bus.ir_in;
            irr_q     <= irr_d;
            isr_q     <= isr_d;
            state_q   <= state_d;
            int_req_q <= int_req_d;
            int_id_q  <= int_id_d;
            spur_q    <= spur_d;
            low_q     <= low_d;
        end
    end

    assign bus.int_req     = int_req_q;
    assign bus.int_id      = int_id_q;
    assign bus.irr         = irr_q;
    assign bus.isr         = isr_q;
    assign bus.lowest_prio = low_q;

endmodule

// File: tb/tb_pic_irq_resolver.sv
// Scoreboard bench: a reference model computes expected outputs at each rising
// edge and queues them; a monitor pops and compares at each falling edge.
module tb_pic_irq_resolver;

    logic clk;
    logic rst_n;

    pic_irq_resolver_if bus ();

    pic_irq_resolver dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       req;
        logic [2:0] id;
        logic [7:0] irr;
        logic [7:0] isr;
        logic [2:0] low;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model state
    logic [7:0] m_irq;
    logic [7:0] m_irr;
    logic [7:0] m_isr;
    bit         m_wait;
    bit         m_req;
    int         m_id;
    bit         m_spur;
    int         m_low;

    function automatic int rank(input int i, input int low);
        return (i - low + 7) % 8;
    endfunction

    // Highest-priority set bit of v relative to low, or -1 if none.
    function automatic int best(input logic [7:0] v, input int low);
        int b = -1;
        for (int i = 0; i < 8; i++)
            if (v[i] && (b < 0 || rank(i, low) < rank(b, low))) b = i;
        return b;
    endfunction

    task automatic model_reset();
        m_irq  = 8'hFF;
        m_irr  = 8'h00;
        m_isr  = 8'h00;
        m_wait = 0;
        m_req  = 0;
        m_id   = 0;
        m_spur = 0;
        m_low  = 7;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: evaluated on the inputs present at each rising edge.
    initial begin
        exp_t e;
        model_reset();
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                model_reset();
            end else begin
                logic [7:0] edges, n_irr, n_isr;
                int c, s, n_low;
                bit n_req;
                edges = bus.ir_in & ~m_irq;
                c = best(m_irr & ~bus.imr, m_low);
                s = best(m_isr, m_low);
                n_req = !m_wait && !bus.ack1 && c >= 0 && (s < 0 || rank(c, m_low) < rank(s, m_low));
                n_isr = m_isr;
                n_low = m_low;
                if (bus.eoi_valid) begin
                    case (bus.eoi_cmd)
                        3'b001: if (s >= 0) n_isr[s] = 1'b0;
                        3'b011: n_isr[bus.eoi_level] = 1'b0;
                        3'b101: if (s >= 0) begin n_isr[s] = 1'b0; n_low = s; end
                        3'b111: begin n_isr[bus.eoi_level] = 1'b0; n_low = int'(bus.eoi_level); end
                        3'b110: n_low = int'(bus.eoi_level);
                        default: ;
                    endcase
                end
                n_irr = bus.ltim ? bus.ir_in : m_irr;
                if (!m_wait && bus.ack1) begin
                    m_wait = 1;
                    if (c >= 0) begin
                        n_isr[c] = 1'b1;
                        n_irr[c] = 1'b0;
                        m_id = c;
                        m_spur = 0;
                    end else begin
                        m_id = 7;
                        m_spur = 1;
                    end
                end else if (m_wait && bus.ack2) begin
                    m_wait = 0;
                    if (bus.aeoi && !m_spur) n_isr[m_id] = 1'b0;
                end
                n_irr  = n_irr | edges;
                m_irr  = n_irr;
                m_isr  = n_isr;
                m_low  = n_low;
                m_req  = n_req;
                m_irq  = bus.ir_in;
            end
            e.req = m_req;
            e.id  = 3'(m_id);
            e.irr = m_irr;
            e.isr = m_isr;
            e.low = 3'(m_low);
            sb.push_back(e);
        end
    end

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("int_req", 8'(bus.int_req), 8'(e.req));
                chk("int_id", 8'(bus.int_id), 8'(e.id));
                chk("irr", bus.irr, e.irr);
                chk("isr", bus.isr, e.isr);
                chk("lowest_prio", 8'(bus.lowest_prio), 8'(e.low));
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
            bus.ack1      = 1'b0;
            bus.ack2      = 1'b0;
            bus.eoi_valid = 1'b0;
        end
    endtask

    task automatic eoi(input logic [2:0] cmd, input logic [2:0] lvl);
        bus.eoi_valid = 1'b1;
        bus.eoi_cmd   = cmd;
        bus.eoi_level = lvl;
        step();
    endtask

    initial begin
        rst_n = 1'b0;
        bus.ir_in = 8'h00; bus.ltim = 1'b0; bus.imr = 8'h00; bus.aeoi = 1'b0;
        bus.ack1 = 1'b0; bus.ack2 = 1'b0; bus.eoi_valid = 1'b0;
        bus.eoi_cmd = 3'b000; bus.eoi_level = 3'd0;
        step(2);
        rst_n = 1'b1;
        step(2);

        // Basic request on IR3
        bus.ir_in = 8'h08; step(3);
        bus.ack1 = 1'b1; step();
        bus.ack2 = 1'b1; step();
        bus.ir_in = 8'h00; step();

        // Nesting: IR5 blocked by IR3 in service, IR1 preempts
        bus.ir_in = 8'h20; step(3);
        bus.ir_in = 8'h22; step(3);
        bus.ack1 = 1'b1; step();
        bus.ack2 = 1'b1; step();

        // EOI non-specific, then rotate-specific on 3; IR4/IR2 then resolve to IR4
        eoi(3'b001, 3'd0);
        eoi(3'b111, 3'd3);
        bus.ir_in = 8'h36; step(3);
        bus.ack1 = 1'b1; step();
        bus.ack2 = 1'b1; step();
        eoi(3'b101, 3'd0);
        eoi(3'b110, 3'd7);
        bus.ack1 = 1'b1; step();
        bus.ack2 = 1'b1; step();
        eoi(3'b001, 3'd0);
        bus.ack1 = 1'b1; step();
        bus.ack2 = 1'b1; step();
        eoi(3'b011, 3'd5);
        bus.ir_in = 8'h00; step();

        // Masking and level-mode withdrawal -> spurious ack
        bus.ltim = 1'b1;
        bus.imr = 8'h04; bus.ir_in = 8'h04; step(3);
        bus.imr = 8'h00; step(2);
        bus.ir_in = 8'h00; step();
        bus.ack1 = 1'b1; step();
        bus.aeoi = 1'b1; bus.ack2 = 1'b1; step();
        bus.ltim = 1'b0;

        // AEOI on IR6, twice
        for (int r = 0; r < 2; r++) begin
            bus.ir_in = 8'h40; step(3);
            bus.ack1 = 1'b1; step();
            bus.ack2 = 1'b1; step();
            bus.ir_in = 8'h00; step(2);
        end
        bus.aeoi = 1'b0;

        // ack1 collides with a fresh edge on the granted bit
        bus.ir_in = 8'h01; step();
        bus.ir_in = 8'h00; step(2);
        bus.ir_in = 8'h01; bus.ack1 = 1'b1; step();
        step(2);

        // Asynchronous reset while waiting for ack2
        rst_n = 1'b0;
        #1;
        chk("rst_int_req", 8'(bus.int_req), 8'h00);
        chk("rst_int_id", 8'(bus.int_id), 8'h00);
        chk("rst_irr", bus.irr, 8'h00);
        chk("rst_isr", bus.isr, 8'h00);
        chk("rst_lowest_prio", 8'(bus.lowest_prio), 8'h07);
        sb.delete();
        model_reset();
        step();
        rst_n = 1'b1;
        bus.ack2 = 1'b1; step();
        bus.ir_in = 8'h00; step(2);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bus.ir_in = bus.ir_in ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            if ($urandom_range(0, 31) == 0) bus.imr = 8'($urandom) & 8'($urandom) & 8'($urandom);
            if ($urandom_range(0, 199) == 0) bus.ltim = ~bus.ltim;
            if ($urandom_range(0, 99) == 0) bus.aeoi = ~bus.aeoi;
            bus.ack1 = ($urandom_range(0, 5) == 0);
            bus.ack2 = ($urandom_range(0, 3) == 0);
            bus.eoi_valid = ($urandom_range(0, 9) == 0);
            bus.eoi_cmd = 3'($urandom_range(0, 7));
            bus.eoi_level = 3'($urandom_range(0, 7));
            step();
        end
        step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pic_irq_resolver.md
Name: pic_irq_resolver

Overview:
- Interrupt request and in-service stage of the PIC, directly upstream of the control logic.
- Latches IR0–IR7 into IRR, applies the IMR mask and resolves priority in fully nested or rotating mode.
- Raises int_req toward the control logic and sets/clears ISR on acknowledge strobes and EOI commands.
- Supplies the 3-bit interrupt id that the control logic concatenates with ICW2[7:3].

Parameters:
- NUM_IRQ, 8, number of request lines; the design supports only 8.
- LOW_PRIO_RST, 3'd7, lowest-priority level after reset, giving IR0 highest priority.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ir_in  in  8  raw interrupt request lines, synchronous to clk.
- ltim  in  1  ICW1 LTIM; 1 = level triggered, 0 = edge triggered.
- imr  in  8  OCW1 mask; 1 = masked.
- aeoi  in  1  ICW4 AEOI bit.
- ack1  in  1  one-cycle strobe for the first INTA pulse.
- ack2  in  1  one-cycle strobe for the second INTA pulse.
- eoi_valid  in  1  one-cycle strobe; an OCW2 write is present.
- eoi_cmd  in  3  OCW2 {R,SL,EOI}.
- eoi_level  in  3  OCW2 L2–L0.
- int_req  out  1  registered interrupt request to the control logic.
- int_id  out  3  id granted at ack1, held until the next ack1.
- irr  out  8  IRR contents.
- isr  out  8  ISR contents.
- lowest_prio  out  3  current lowest-priority level L.

Behaviour:
Reset:
- irr=0, isr=0, int_req=0, int_id=0, lowest_prio=LOW_PRIO_RST, state=IDLE.
- Edge-detect register ir_q resets to 8'hFF, so lines already high at reset do not trigger.

IRR update, every cycle:
- Edge mode: bit i sets when ir_in[i] & ~ir_q[i], and holds until cleared by ack1.
- Level mode: bit i = ir_in[i], except it is cleared in the cycle of ack1 for the granted bit.
- ir_q <= ir_in every cycle.

Priority:
- Highest priority is (L+1) mod 8, then descending cyclically; L itself is lowest.
- Candidate c = highest-priority bit of irr & ~imr.
- Top in-service level s = highest-priority bit of isr.

int_req:
- Next value is 1 iff state=IDLE, a candidate exists, and (isr==0 or c has strictly higher priority than s).
- Latency: ir_in rises in cycle n -> irr set at edge n+1 -> int_req high after edge n+2.

FSM:
- IDLE -> WAIT_ACK2 on ack1. Captures int_id=c, sets isr[c], clears irr[c].
- Spurious case: if no candidate exists at ack1, int_id=7 and isr/irr are unchanged.
- WAIT_ACK2 -> IDLE on ack2. If aeoi=1, clears isr[int_id], except on a spurious ack.
- int_req is forced 0 in WAIT_ACK2.
- ack2 in IDLE is ignored. ack1 in WAIT_ACK2 is ignored.

EOI (eoi_valid), by eoi_cmd:
- 001 non-specific: clear bit s. No-op if isr==0.
- 011 specific: clear isr[eoi_level].
- 101 rotate on non-specific: clear bit s and set L=s. No-op if isr==0.
- 111 rotate on specific: clear isr[eoi_level] and set L=eoi_level.
- 110 set priority: L=eoi_level, ISR unchanged.
- 000, 010, 100: no-op.

Simultaneous events:
- EOI and ack1 in the same cycle: the EOI clear is applied to the old ISR, then the ack1 set; set wins on the same bit.
- Candidate selection at ack1 uses the old L, even if the same-cycle EOI rotates L.
- A new rising edge on the bit being cleared by ack1: set wins, and irr[i] stays 1.
- Asynchronous reset mid-sequence returns to IDLE with all reset values; a pending ack2 is lost.

Decomposition:
- pic_pkg holds:
  - state enum {IDLE, WAIT_ACK2};
  - eoi_cmd encodings (EOI_NS=3'b001, EOI_SP=3'b011, ROT_NS=3'b101, ROT_SP=3'b111, SET_PRIO=3'b110);
  - SPURIOUS_ID=3'd7.
- Sub-module pic_rot_prio_enc is a combinational rotating priority encoder.
  - Inputs: vec[7:0], low[2:0]. Outputs: valid, idx[2:0].
  - Instantiated twice: once for irr & ~imr and once for isr.

Test Plan:
- Reset, then a rising edge on ir_in=8'h08 with imr=0 -> irr=8'h08 after 1 edge, int_req=1 after 2; ack1 -> int_id=3, isr=8'h08, irr=0, int_req=0; ack2 -> IDLE.
- Nesting: isr=8'h08 (IR3 in service), raise IR5 -> int_req stays 0; raise IR1 -> int_req=1; ack1 -> int_id=1, isr=8'h0A.
- EOI: isr=8'h0A with eoi_cmd=001 -> isr=8'h08. Then eoi_cmd=111, eoi_level=3 -> isr=0 and lowest_prio=3. Now IR4 and IR2 pending -> ack1 gives int_id=4.
- Masking, spurious and level mode:
  - imr=8'h04 with IR2 pending -> int_req=0.
  - A request withdrawn in level mode before ack1 -> ack1 gives int_id=7, isr unchanged.
- AEOI: aeoi=1, IR6 edge, ack1 then ack2 -> isr returns to 0 in the cycle after ack2; a further IR6 edge is honoured.
- Collisions and reset:
  - ack1 plus a same-bit rising edge -> irr bit stays 1.
  - Assert rst_n=0 in WAIT_ACK2 -> all outputs return to reset values immediately, without waiting for a clock edge.
